store_narrow_rmw: RTL and testbench



---
 rtl/store_narrow_rmw.sv | 147 ++++++++++++++
 tb/tb_store_narrow_rmw.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_rmw.sv
// Narrow store unit: byte/half stores by read-modify-write into a word-only memory.
// Optional LAST_WORD_CACHE_EN keeps the last written word to skip the read on a hit.
module store_narrow_rmw #(
  parameter int ADDR_W     = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata
);

  generate
    if (MEM_RD_LAT != 1) begin : g_lat_chk
      $error("store_narrow_rmw: only MEM_RD_LAT=1 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic [1:0]        size_q;
  logic              accept, align_ok, good, narrow, hit;
  logic [31:0]       merge_src, merged;

  assign accept = st_valid && st_ready;
  assign good   = accept && align_ok;
  assign narrow = ~st_size[1];

  always_comb begin
    align_ok = 1'b0;
    unique case (st_size)
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~st_addr[0];
      2'b10:   align_ok = (st_addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

`ifdef LAST_WORD_CACHE_EN
  logic              c_valid, hit_q;
  logic [ADDR_W-3:0] c_addr;
  logic [31:0]       c_data;

  assign hit       = c_valid && (c_addr == st_addr[ADDR_W-1:2]);
  assign merge_src = hit_q ? c_data : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_addr  <= '0;
      c_data  <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (state == IDLE && good)
        hit_q <= narrow && hit;
      if (state == WRITE) begin
        c_valid <= 1'b1;
        c_addr  <= addr_q[ADDR_W-1:2];
        c_data  <= mem_wdata;
      end
    end
  end
`else
  assign hit       = 1'b0;
  assign merge_src = mem_rdata;
`endif

  // Replace only the addressed lane of the fetched word
  always_comb begin
    merged = merge_src;
    if (size_q == 2'b01) begin
      if (addr_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      unique case (addr_q[1:0])
        2'b00: merged[7:0]   = data_q[7:0];
        2'b01: merged[15:8]  = data_q[7:0];
        2'b10: merged[23:16] = data_q[7:0];
        2'b11: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    st_ready  = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    st_done   = 1'b0;
    unique case (state)
      IDLE: begin
        st_ready = 1'b1;
        if (good)
          state_nx = narrow ? (hit ? MERGE : READ) : WRITE;
      end
      READ: begin
        mem_rd_en = 1'b1;
        state_nx  = MERGE;
      end
      MERGE: state_nx = WRITE;
      WRITE: begin
        mem_wr_en = 1'b1;
        st_done   = 1'b1;
        state_nx  = IDLE;
      end
    endcase
  end

  assign mem_addr = addr_q[ADDR_W-1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= '0;
      mem_wdata <= '0;
      st_err    <= 1'b0;
    end else begin
      state  <= state_nx;
      st_err <= accept && !align_ok;
      if (good) begin
        addr_q <= st_addr;
        data_q <= st_data[15:0];
        size_q <= st_size;
        if (!narrow)
          mem_wdata <= st_data;
      end
      if (state == MERGE)
        mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Testbench for store_narrow_rmw: directed and random stores against a word-level reference.
// Define LAST_WORD_CACHE_EN for both bench and RTL to check the cache timing.
module tb_store_narrow_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        st_err;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;

  store_narrow_rmw #(.ADDR_W(32), .MEM_RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_done(st_done), .st_err(st_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[5:0]];
    if (mem_wr_en) mem[mem_addr[5:0]] = mem_wdata;
  end

`ifdef LAST_WORD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  bit          last_valid = 1'b0;
  logic [29:0] last_waddr = '0;
  logic [29:0] held_addr  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ready"}, 32'(st_ready), 32'd1);
    chk({tag, ".done"}, 32'(st_done), 32'd0);
    chk({tag, ".err"}, 32'(st_err), 32'd0);
    chk({tag, ".rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, ".wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, ".addr"}, 32'(mem_addr), 32'd0);
    chk({tag, ".wdata"}, mem_wdata, 32'd0);
  endtask

  // Word image after a store, from plain byte arithmetic
  function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] s);
    int sh;
    logic [31:0] m;
    sh = 8 * int'(a[1:0]);
    if (s == 2'd2) return d;
    m = (s == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (old & ~(m << sh)) | ((d & m) << sh);
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bit bad, hit, excl_ok, done_ok, ready_ok;
    int n_rd, n_wr, n_ep, rd_cyc, wr_cyc, ep_cyc, exp_rd, exp_wr;
    logic [29:0] w, wa_seen, ra_seen;
    logic [31:0] wd_seen, exp_w;
    bad = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    w = a[31:2];
    n_rd = 0; n_wr = 0; n_ep = 0; rd_cyc = 0; wr_cyc = 0; ep_cyc = 0;
    excl_ok = 1; done_ok = 1; ready_ok = 1;
    wa_seen = '0; ra_seen = '0; wd_seen = '0;
    @(negedge clk);
    chk("ready_idle", 32'(st_ready), 32'd1);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
    @(posedge clk);
    #1 st_valid = 1'b0; st_data = $urandom; st_addr = $urandom; st_size = 2'($urandom);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin n_rd++; rd_cyc = c; ra_seen = mem_addr; end
      if (mem_wr_en) begin n_wr++; wr_cyc = c; wa_seen = mem_addr; wd_seen = mem_wdata; end
      if (st_err) begin n_ep++; ep_cyc = c; end
      if (mem_rd_en && mem_wr_en) excl_ok = 0;
      if (st_done !== mem_wr_en) done_ok = 0;
      if (!st_ready) ready_ok = 0;
    end
    chk("rd_wr_exclusive", 32'(excl_ok), 32'd1);
    chk("done_with_write", 32'(done_ok), 32'd1);
    if (bad) begin
      chk("err_cycle", 32'(ep_cyc), 32'd1);
      chk("err_pulses", 32'(n_ep), 32'd1);
      chk("err_no_rd", 32'(n_rd), 32'd0);
      chk("err_no_wr", 32'(n_wr), 32'd0);
      chk("err_ready_high", 32'(ready_ok), 32'd1);
      chk("err_addr_held", 32'(mem_addr), 32'(held_addr));
    end else begin
      hit = CACHE && last_valid && last_waddr == w && s != 2'd2;
      exp_w = apply(ref_mem[w[5:0]], a, d, s);
      ref_mem[w[5:0]] = exp_w;
      exp_wr = (s == 2'd2) ? 1 : (hit ? 2 : 3);
      exp_rd = (s == 2'd2 || hit) ? 0 : 1;
      chk("wr_cycle", 32'(wr_cyc), 32'(exp_wr));
      chk("wr_count", 32'(n_wr), 32'd1);
      chk("rd_count", 32'(n_rd), 32'(exp_rd));
      if (exp_rd == 1) begin
        chk("rd_cycle", 32'(rd_cyc), 32'd1);
        chk("rd_addr", 32'(ra_seen), 32'(w));
      end
      chk("wr_addr", 32'(wa_seen), 32'(w));
      chk("wr_data", wd_seen, exp_w);
      chk("no_err", 32'(n_ep), 32'd0);
      chk("addr_held_idle", 32'(mem_addr), 32'(w));
      last_valid = 1'b1; last_waddr = w; held_addr = w;
    end
    chk("mem_word", mem[w[5:0]], ref_mem[w[5:0]]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1 chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
    last_valid = 1'b0; held_addr = '0;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[16] = 32'hAABBCCDD; ref_mem[16] = 32'hAABBCCDD;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;

    store(32'h41, 32'h0000_0011, 2'd0);
    chk("sb_result", ref_mem[16], 32'hAABB11DD);

    do_reset();
    mem[16] = 32'hAABBCCDD; ref_mem[16] = 32'hAABBCCDD;
    store(32'h42, 32'hFFFF_1234, 2'd1);
    chk("sh_result", ref_mem[16], 32'h1234CCDD);

    store(32'h80, 32'hDEADBEEF, 2'd2);
    store(32'h43, 32'h1111_2222, 2'd1);
    store(32'h82, 32'h3333_4444, 2'd2);
    store(32'h40, 32'h5555_6666, 2'd3);

    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h41; st_data = 32'h0000_0077; st_size = 2'd0;
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 chk_reset_vals("mid");
    @(negedge clk);
    chk("mid_no_wr", 32'(mem_wr_en), 32'd0);
    chk("mid_mem", mem[16], ref_mem[16]);
    reset = 1'b0;
    last_valid = 1'b0; held_addr = '0;

    store(32'h40, 32'h11223344, 2'd2);
    store(32'h40, 32'h0000_0055, 2'd0);
    chk("cache_result", ref_mem[16], 32'h11223355);

    for (int k = 0; k < 40; k++)
      store(32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
